stream_fifo_arbiter: RTL and testbench

- Round-robin scheduler sharing one StreamingFIFO (Q_srl-based, AXI-stream, exposes occupancy `count`) among N_IN AXI-stream producers.
- Grants one producer at a time for a burst of BURST_LEN beats, and only when the FIFO has at least BURST_LEN free entries.
- Releases early if the granted producer stalls for STALL_TIMEOUT cycles.
- Sits directly in front of the FIFO instance; the FIFO's `count` output closes the loop.

---
 rtl/stream_fifo_arbiter_pkg.sv | 29 ++
 rtl/stream_fifo_arbiter_if.sv | 33 +++
 rtl/stream_fifo_arbiter_rr_pick.sv | 27 ++
 rtl/stream_fifo_arbiter.sv | 113 +++++++++++
 tb/tb_stream_fifo_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_arbiter_pkg.sv
// Shared types, sizing helper and default widths for the stream FIFO arbiter.
package stream_fifo_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Ceiling log2, never narrower than one bit so it can size any vector.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    if (v > 1) begin
      for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
        r++;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_N_IN          = 4;
  localparam int unsigned DEF_BURST_LEN     = 16;
  localparam int unsigned DEF_STALL_TIMEOUT = 32;

  localparam int unsigned GRANT_W = clog2(DEF_N_IN);
  localparam int unsigned BEAT_W  = clog2(DEF_BURST_LEN + 1);
  localparam int unsigned STALL_W = clog2(DEF_STALL_TIMEOUT + 1);

endpackage

// File: rtl/stream_fifo_arbiter_if.sv
// Producer streams, FIFO-side stream, occupancy and grant status bundle.
interface stream_fifo_arbiter_if
  import stream_fifo_arbiter_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 13
);
  logic [N_IN*WIDTH-1:0] in_V_V_TDATA;
  logic [N_IN-1:0]       in_V_V_TVALID;
  logic [N_IN-1:0]       in_V_V_TREADY;
  logic [WIDTH-1:0]      fifo_V_V_TDATA;
  logic                  fifo_V_V_TVALID;
  logic                  fifo_V_V_TREADY;
  logic [CNT_W-1:0]      fifo_count;
  logic                  grant_valid;
  logic [clog2(N_IN)-1:0] grant_id;
  logic                  burst_done;

  // Arbiter side.
  modport master (
    input  in_V_V_TDATA, in_V_V_TVALID, fifo_V_V_TREADY, fifo_count,
    output in_V_V_TREADY, fifo_V_V_TDATA, fifo_V_V_TVALID,
    output grant_valid, grant_id, burst_done
  );

  // Producer / FIFO / observer side.
  modport slave (
    output in_V_V_TDATA, in_V_V_TVALID, fifo_V_V_TREADY, fifo_count,
    input  in_V_V_TREADY, fifo_V_V_TDATA, fifo_V_V_TVALID,
    input  grant_valid, grant_id, burst_done
  );
endinterface

// File: rtl/stream_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick #(
  parameter int unsigned N_IN = 4,
  parameter int unsigned GW   = 2
) (
  input  logic [N_IN-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   sel,
  output logic            found
);

  // Scan last_grant+1 .. last_grant+N_IN modulo N_IN, keep the first hit.
  always_comb begin
    logic [GW-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_IN; k++) begin
      idx = GW'((32'(last_grant) + k) % N_IN);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/stream_fifo_arbiter.sv
// Round-robin burst scheduler in front of a shared stream FIFO.
module stream_fifo_arbiter
  import stream_fifo_arbiter_pkg::*;
#(
  parameter int unsigned N_IN          = DEF_N_IN,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 8192,
  parameter int unsigned CNT_W         = 13,
  parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
  parameter int unsigned STALL_TIMEOUT = DEF_STALL_TIMEOUT
) (
  input  logic ap_clk,
  input  logic ap_rst,
  stream_fifo_arbiter_if.master bus
);

  localparam int unsigned GW = clog2(N_IN);
  localparam int unsigned BW = clog2(BURST_LEN + 1);
  localparam int unsigned SW = clog2(STALL_TIMEOUT + 1);

  localparam logic [CNT_W:0] SPACE_LIM  = (CNT_W+1)'(DEPTH - BURST_LEN);
  localparam logic [BW-1:0]  BEAT_LAST  = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0]  BEAT_MAX   = BW'(BURST_LEN);
  localparam logic [SW-1:0]  STALL_LAST = SW'(STALL_TIMEOUT - 1);
  localparam logic [SW-1:0]  STALL_MAX  = SW'(STALL_TIMEOUT);

  state_t          state, next_state;
  logic [GW-1:0]   grant_id_q, last_grant, pick_id;
  logic            grant_valid_q, burst_done_q;
  logic [BW-1:0]   beat_cnt;
  logic [SW-1:0]   stall_cnt;
  logic            pick_found, space_ok, start, g_valid, beat, rel;
  logic [WIDTH-1:0] slice [N_IN];

  for (genvar i = 0; i < N_IN; i++) begin : g_slice
    assign slice[i] = bus.in_V_V_TDATA[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N_IN(N_IN), .GW(GW)) u_pick (
    .req        (bus.in_V_V_TVALID),
    .last_grant (last_grant),
    .sel        (pick_id),
    .found      (pick_found)
  );

  // Arbitration and release conditions.
  always_comb begin
    space_ok = ({1'b0, bus.fifo_count} <= SPACE_LIM);
    start    = (state == IDLE) && space_ok && pick_found;
    g_valid  = bus.in_V_V_TVALID[grant_id_q];
    beat     = (state == XFER) && g_valid && bus.fifo_V_V_TREADY;
    rel      = (beat && (beat_cnt == BEAT_LAST)) ||
               ((state == XFER) && !g_valid && (stall_cnt == STALL_LAST));
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = XFER;
      XFER:    if (rel)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stream pass-through for the grantee; nothing handshakes in IDLE.
  always_comb begin
    bus.fifo_V_V_TDATA  = '0;
    bus.fifo_V_V_TVALID = 1'b0;
    bus.in_V_V_TREADY   = '0;
    if (state == XFER) begin
      bus.fifo_V_V_TDATA              = slice[grant_id_q];
      bus.fifo_V_V_TVALID             = g_valid;
      bus.in_V_V_TREADY[grant_id_q]   = bus.fifo_V_V_TREADY;
    end
  end

  // Grant bookkeeping and saturating beat/stall counters.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_done_q  <= 1'b0;
      last_grant    <= GW'(N_IN - 1);
      beat_cnt      <= '0;
      stall_cnt     <= '0;
    end else begin
      burst_done_q  <= rel;
      grant_valid_q <= (next_state == XFER);
      if (start) begin
        grant_id_q <= pick_id;
        beat_cnt   <= '0;
        stall_cnt  <= '0;
      end else if (state == XFER) begin
        if (beat && (beat_cnt != BEAT_MAX)) beat_cnt <= beat_cnt + 1'b1;
        if (g_valid)                         stall_cnt <= '0;
        else if (stall_cnt != STALL_MAX)     stall_cnt <= stall_cnt + 1'b1;
        if (rel) last_grant <= grant_id_q;
      end
    end
  end

  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.burst_done  = burst_done_q;

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Self-checking bench for stream_fifo_arbiter (N_IN=4, BURST_LEN=16, STALL_TIMEOUT=32).
module tb_stream_fifo_arbiter;
  import stream_fifo_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 13;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  stream_fifo_arbiter_if #(.N_IN(N), .WIDTH(W), .CNT_W(CW)) bus ();

  stream_fifo_arbiter #(
    .N_IN(N), .WIDTH(W), .DEPTH(8192), .CNT_W(CW),
    .BURST_LEN(16), .STALL_TIMEOUT(32)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [N-1:0]  tvalid;
    logic [CW-1:0] count;
    logic          exp_gv;
    logic [1:0]    exp_id;
  } vec_t;

  vec_t       vecs [8];
  int         checks = 0;
  int         failures = 0;
  int         seq [N];
  int         beats [N];
  logic [W-1:0] sb [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pdata(input int i);
    return W'((i << 6) | (seq[i] & 63));
  endfunction

  task automatic drive_data();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) d = d | ((N*W)'(pdata(i)) << (i * W));
    bus.in_V_V_TDATA = d;
  endtask

  // One clock: note producer handshakes, advance past the edge, update producer data.
  task automatic tick();
    logic [N-1:0] hs;
    #1;
    hs = bus.in_V_V_TVALID & bus.in_V_V_TREADY;
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
    drive_data();
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    bus.in_V_V_TVALID   = '0;
    bus.fifo_V_V_TREADY = 1'b1;
    bus.fifo_count      = '0;
    tick();
    tick();
    ap_rst = 1'b0;
    #1;
  endtask

  // Scoreboard: each producer handshake pushes its expected word, each FIFO handshake pops one.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < N; i++) begin
        if (bus.in_V_V_TVALID[i] && bus.in_V_V_TREADY[i]) begin
          sb.push_back(pdata(i));
          beats[i]++;
        end
      end
      if (bus.fifo_V_V_TVALID && bus.fifo_V_V_TREADY) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("fifo_data", int'(bus.fifo_V_V_TDATA), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b2, cycles, steps, hs_cnt, bad, held, done;
    int bb [N];

    vecs[0] = '{4'b0001, 13'd0,    1'b1, 2'd0};
    vecs[1] = '{4'b0010, 13'd0,    1'b1, 2'd1};
    vecs[2] = '{4'b1100, 13'd0,    1'b1, 2'd2};
    vecs[3] = '{4'b1000, 13'd8176, 1'b1, 2'd3};
    vecs[4] = '{4'b0001, 13'd8177, 1'b0, 2'd0};
    vecs[5] = '{4'b0000, 13'd0,    1'b0, 2'd0};
    vecs[6] = '{4'b1111, 13'd8191, 1'b0, 2'd0};
    vecs[7] = '{4'b0110, 13'd8176, 1'b1, 2'd1};

    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      beats[i] = 0;
    end
    bus.in_V_V_TVALID   = '0;
    bus.fifo_V_V_TREADY = 1'b1;
    bus.fifo_count      = '0;
    drive_data();

    // Reset state.
    tick();
    chk("rst_gv", int'(bus.grant_valid), 0);
    chk("rst_id", int'(bus.grant_id), 0);
    chk("rst_bd", int'(bus.burst_done), 0);
    chk("rst_tready", int'(bus.in_V_V_TREADY), 0);
    chk("rst_fvalid", int'(bus.fifo_V_V_TVALID), 0);
    ap_rst = 1'b0;

    // Table: first arbitration from reset under different requests / occupancies.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      bus.in_V_V_TVALID = vecs[v].tvalid;
      bus.fifo_count    = vecs[v].count;
      #1;
      chk($sformatf("vec%0d_idle_tready", v), int'(bus.in_V_V_TREADY), 0);
      chk($sformatf("vec%0d_idle_fvalid", v), int'(bus.fifo_V_V_TVALID), 0);
      tick();
      chk($sformatf("vec%0d_gv", v), int'(bus.grant_valid), int'(vecs[v].exp_gv));
      chk($sformatf("vec%0d_id", v), int'(bus.grant_id), int'(vecs[v].exp_id));
    end

    // Single requester: 16 beats, release, one IDLE bubble, regrant.
    do_reset();
    bus.in_V_V_TVALID = 4'b0001;
    b0 = beats[0];
    tick();
    chk("A_gv", int'(bus.grant_valid), 1);
    chk("A_id", int'(bus.grant_id), 0);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.fifo_V_V_TVALID !== 1'b1 || bus.in_V_V_TREADY !== 4'b0001) bad++;
      tick();
    end
    chk("A_pass", bad, 0);
    chk("A_bd", int'(bus.burst_done), 1);
    chk("A_gv_idle", int'(bus.grant_valid), 0);
    chk("A_fvalid_idle", int'(bus.fifo_V_V_TVALID), 0);
    chk("A_id_hold", int'(bus.grant_id), 0);
    chk("A_beats", beats[0] - b0, 16);
    tick();
    chk("A_regrant", int'(bus.grant_valid), 1);
    chk("A_regrant_id", int'(bus.grant_id), 0);
    chk("A_bd_pulse", int'(bus.burst_done), 0);

    // All four requesting: order 0,1,2,3,0 at 17 cycles per burst.
    do_reset();
    bus.in_V_V_TVALID = 4'b1111;
    for (int i = 0; i < N; i++) bb[i] = beats[i];
    tick();
    cycles = 0;
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("B_id%0d", b), int'(bus.grant_id), b % 4);
      chk($sformatf("B_gv%0d", b), int'(bus.grant_valid), 1);
      if (b < 4) begin
        repeat (16) tick();
        chk($sformatf("B_bd%0d", b), int'(bus.burst_done), 1);
        tick();
        cycles += 17;
      end
    end
    chk("B_cycles", cycles, 68);
    for (int i = 0; i < N; i++) chk($sformatf("B_beats%0d", i), beats[i] - bb[i], 16);

    // Occupancy boundary: 8177 holds IDLE, 8176 grants on the next edge.
    do_reset();
    bus.in_V_V_TVALID = 4'b0001;
    bus.fifo_count = 13'd8177;
    bad = 0;
    repeat (3) begin
      tick();
      if (bus.grant_valid !== 1'b0 || bus.in_V_V_TREADY !== 4'b0000 || bus.fifo_V_V_TVALID !== 1'b0) bad++;
    end
    chk("C_hold", bad, 0);
    bus.fifo_count = 13'd8176;
    tick();
    chk("C_gv", int'(bus.grant_valid), 1);
    chk("C_id", int'(bus.grant_id), 0);

    // Stall timeout: grantee 2 sends 5 beats then idles 32 cycles.
    do_reset();
    bus.in_V_V_TVALID = 4'b1100;
    tick();
    chk("D_id", int'(bus.grant_id), 2);
    b2 = beats[2];
    repeat (5) tick();
    bus.in_V_V_TVALID = 4'b1000;
    held = 1;
    for (int k = 0; k < 31; k++) begin
      tick();
      if (bus.grant_valid !== 1'b1) held = 0;
    end
    chk("D_held", held, 1);
    tick();
    chk("D_bd", int'(bus.burst_done), 1);
    chk("D_gv", int'(bus.grant_valid), 0);
    chk("D_beats", beats[2] - b2, 5);
    tick();
    chk("D_next_id", int'(bus.grant_id), 3);
    chk("D_next_gv", int'(bus.grant_valid), 1);

    // Backpressure: FIFO ready alternates; burst ends after 16 handshakes.
    do_reset();
    bus.in_V_V_TVALID = 4'b0011;
    tick();
    chk("E_id", int'(bus.grant_id), 0);
    b0 = beats[0];
    hs_cnt = 0;
    steps = 0;
    done = 0;
    bad = 0;
    while (!done && steps < 64) begin
      bus.fifo_V_V_TREADY = (steps % 2 == 0);
      #1;
      if ((bus.in_V_V_TREADY & 4'b1110) != 4'b0000) bad++;
      if (bus.in_V_V_TREADY[0] !== bus.fifo_V_V_TREADY) bad++;
      if (bus.fifo_V_V_TVALID && bus.fifo_V_V_TREADY) hs_cnt++;
      tick();
      steps++;
      if (bus.burst_done) done = 1;
    end
    bus.fifo_V_V_TREADY = 1'b1;
    chk("E_done", done, 1);
    chk("E_steps", steps, 31);
    chk("E_hs", hs_cnt, 16);
    chk("E_beats", beats[0] - b0, 16);
    chk("E_tready_mask", bad, 0);

    // Asynchronous reset between edges during beat 7.
    do_reset();
    bus.in_V_V_TVALID = 4'b0011;
    tick();
    chk("F_id", int'(bus.grant_id), 0);
    repeat (7) tick();
    #1;
    ap_rst = 1'b1;
    #1;
    chk("F_tready", int'(bus.in_V_V_TREADY), 0);
    chk("F_fvalid", int'(bus.fifo_V_V_TVALID), 0);
    chk("F_gv", int'(bus.grant_valid), 0);
    tick();
    ap_rst = 1'b0;
    tick();
    chk("F_regrant_gv", int'(bus.grant_valid), 1);
    chk("F_regrant_id", int'(bus.grant_id), 0);

    bus.in_V_V_TVALID = '0;
    tick();
    chk("sb_left", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
